burst_qualifier: RTL and testbench
==================================

BURST_QUALIFIER -- requirements
Module: burst_qualifier

Interface
REQ-001 The parameter CLKS_PER_PERIOD SHALL default to 6 and set the nominal modulation period in clk cycles (81 MHz / 13.5 MHz).
REQ-002 The parameter PERIOD_TOL SHALL default to 1 and set the accepted period deviation in cycles (±).
REQ-003 The parameter MIN_CYCLES SHALL default to 4 and set the number of consecutive valid periods needed to qualify a burst (legal range 2..255).
REQ-004 The parameter TIMEOUT SHALL default to 121 and set the edge-free cycles (about 1.5 us) that end a qualified burst.
REQ-005 The port clk SHALL be a 1-bit input: the single clock; all logic on its rising edge.
REQ-006 The port reset SHALL be a 1-bit input: synchronous, active-high reset.
REQ-007 The port in SHALL be a 1-bit input: raw asynchronous receiver comparator output.
REQ-008 The port detect SHALL be a 1-bit output: one-cycle pulse when a burst qualifies; it feeds the delay-line edge input.
REQ-009 The port active SHALL be a 1-bit output: high while a qualified burst is in progress.
REQ-010 The port cycle_count SHALL be an 8-bit output: count of valid periods in the last completed burst.
REQ-011 The port count_valid SHALL be a 1-bit output: one-cycle strobe marking that cycle_count has been updated.

Function
REQ-012 in SHALL pass through a 2-flop synchroniser; rise = in_sync AND NOT in_sync_d.
REQ-013 A period counter SHALL load 1 on every rise and increment otherwise, saturating at TIMEOUT+1; at a rise its value is the measured period.
REQ-014 A period SHALL be valid iff CLKS_PER_PERIOD-PERIOD_TOL <= period <= CLKS_PER_PERIOD+PERIOD_TOL.
REQ-015 The FSM SHALL have three states: IDLE, MEASURE, QUALIFIED; the reset state is IDLE.
REQ-016 IDLE: on a rise, go to MEASURE and clear the valid-period count; all other inputs are ignored.
REQ-017 MEASURE, valid-period rise: increment the count; when the count reaches MIN_CYCLES, pulse detect and go to QUALIFIED.
REQ-018 MEASURE, invalid-period rise: clear the count and stay in MEASURE; that rise starts a new measurement.
REQ-019 MEASURE, no rise while the counter exceeds CLKS_PER_PERIOD+PERIOD_TOL: go to IDLE; a rise arriving exactly at the limit counts as valid.
REQ-020 QUALIFIED: active=1; each valid rise increments the count, saturating at 255; invalid rises are ignored; detect is never reasserted.
REQ-021 QUALIFIED, counter reaches TIMEOUT with no rise: go to IDLE, load cycle_count with the count, and pulse count_valid for one cycle.
REQ-022 Latency: detect SHALL be asserted exactly 3 clk cycles after the first clk edge that samples in high for the qualifying rise (2 synchroniser + 1 register); this is fixed and data-independent.
REQ-023 All outputs SHALL be registered; detect and count_valid are single-cycle pulses.

Reset
REQ-024 While reset is high (sampled at a clk edge), the block SHALL set the state to IDLE, clear the synchroniser and counters, and drive detect=0, active=0, cycle_count=0 and count_valid=0.
REQ-025 Reset asserted mid-burst SHALL abort the burst with no count_valid pulse; the first rise after release SHALL be treated as coming from IDLE.

Configuration
REQ-026 With macro BURST_QUALIFIER_STATS_EN defined, the valid-period counting in QUALIFIED and the cycle_count/count_valid logic SHALL be compiled in.
REQ-027 Without BURST_QUALIFIER_STATS_EN, cycle_count and count_valid SHALL be constant 0; detect and active behaviour and timing SHALL be identical to the defined case.

Structure
REQ-028 Package burst_qualifier_pkg SHALL hold the FSM state encoding, LATENCY = 3, and the default CLKS_PER_PERIOD, PERIOD_TOL, MIN_CYCLES and TIMEOUT values.
REQ-029 The synchroniser SHALL be the sub-module sync_2ff, reusable in other blocks.

Verification (defaults; STATS_EN defined unless noted)
REQ-030 12 rises at a 6-cycle period -> one detect, 3 cycles after sampling the 5th rise; then 122 cycles after the last rise, count_valid with cycle_count=11.
REQ-031 Rises at a 9-cycle period for 20 periods -> detect, active and count_valid stay 0 throughout.
REQ-032 Periods 5,7,6,7 -> detect after the 4th; periods 4 or 8 anywhere in the sequence -> the count restarts.
REQ-033 3 periods of 6, then 1 period of 10, then 4 periods of 6 -> exactly one detect, after the second run.
REQ-034 Reset pulsed 20 cycles into QUALIFIED -> all outputs 0 on the next cycle, no count_valid; a new 5-rise burst qualifies normally.
REQ-035 STATS_EN undefined, stimulus as REQ-030 -> detect timing identical; cycle_count and count_valid stay 0.

Source files
------------

// File: rtl/burst_qualifier_pkg.sv
// burst_qualifier_pkg: state encoding and default timing values shared by
// burst_qualifier and anything that needs to reason about its timing.
package burst_qualifier_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_MEASURE   = 2'd1,
      ST_QUALIFIED = 2'd2
   } state_t;

   // Input-to-detect delay in clk edges: two synchroniser stages plus the output register.
   localparam int LATENCY = 3;

   // 81 MHz clock over a 13.5 MHz modulation gives a 6-cycle nominal period.
   localparam int DEF_CLKS_PER_PERIOD = 6;
   localparam int DEF_PERIOD_TOL      = 1;
   localparam int DEF_MIN_CYCLES      = 4;
   // Roughly 1.5 us of silence at 81 MHz ends a qualified burst.
   localparam int DEF_TIMEOUT         = 121;

   localparam logic [7:0] COUNT_MAX = 8'd255;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous bit.
// Both stages clear on the synchronous active-high reset.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic meta_d;
   logic sync_q;
   logic sync_d;

   // Next values simply shift the input one stage further along the chain.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Register both stages; reset clears the chain so no stale level survives.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/burst_qualifier.sv
// burst_qualifier: qualifies bursts of a modulated receiver signal by measuring
// the period between rising edges. A burst qualifies after MIN_CYCLES
// consecutive in-tolerance periods (one-cycle detect pulse) and stays active
// until TIMEOUT edge-free cycles pass.
// Optional macro BURST_QUALIFIER_STATS_EN compiles in the per-burst valid
// period count reported on cycle_count/count_valid; without it those outputs
// are constant 0 and detect/active behave identically.
module burst_qualifier
   import burst_qualifier_pkg::*;
#(
   parameter int CLKS_PER_PERIOD = DEF_CLKS_PER_PERIOD,
   parameter int PERIOD_TOL      = DEF_PERIOD_TOL,
   parameter int MIN_CYCLES      = DEF_MIN_CYCLES,
   parameter int TIMEOUT         = DEF_TIMEOUT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in,
   output logic       detect,
   output logic       active,
   output logic [7:0] cycle_count,
   output logic       count_valid
);

   // Period counter must hold TIMEOUT+1, where it saturates.
   localparam int PW = $clog2(TIMEOUT + 2);
   localparam logic [PW-1:0] PCNT_MAX  = PW'(TIMEOUT + 1);
   localparam logic [PW-1:0] PCNT_TMO  = PW'(TIMEOUT);
   localparam logic [PW-1:0] PER_LO    = PW'(CLKS_PER_PERIOD - PERIOD_TOL);
   localparam logic [PW-1:0] PER_HI    = PW'(CLKS_PER_PERIOD + PERIOD_TOL);
   localparam logic [7:0]    MIN_COUNT = 8'(MIN_CYCLES);

   logic          in_sync;
   logic          in_dly_q;
   logic          in_dly_d;
   logic          rise;
   logic [PW-1:0] pcnt_q;
   logic [PW-1:0] pcnt_d;
   logic          period_ok;
   logic          over_limit;
   logic          timed_out;
   state_t        state_q;
   state_t        state_d;
   logic [7:0]    count_q;
   logic [7:0]    count_d;
   logic          detect_q;
   logic          detect_d;
   logic          active_q;
   logic          active_d;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (in),
      .q     (in_sync)
   );

   // Edge detect and period measurement: the counter value seen at a rise is the period.
   always_comb begin
      in_dly_d   = in_sync;
      rise       = in_sync & ~in_dly_q;
      if (rise) begin
         pcnt_d = {{(PW-1){1'b0}}, 1'b1};
      end else if (pcnt_q == PCNT_MAX) begin
         pcnt_d = pcnt_q;
      end else begin
         pcnt_d = pcnt_q + {{(PW-1){1'b0}}, 1'b1};
      end
      period_ok  = (pcnt_q >= PER_LO) && (pcnt_q <= PER_HI);
      over_limit = (pcnt_q > PER_HI);
      timed_out  = (pcnt_q >= PCNT_TMO);
   end

`ifdef BURST_QUALIFIER_STATS_EN
   logic [7:0] cycle_count_q;
   logic [7:0] cycle_count_d;
   logic       count_valid_q;
   logic       count_valid_d;
`endif

   // Burst FSM next-state logic: measure, qualify, then hold until the line goes quiet.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      detect_d = 1'b0;
`ifdef BURST_QUALIFIER_STATS_EN
      cycle_count_d = cycle_count_q;
      count_valid_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               state_d = ST_MEASURE;
               count_d = 8'd0;
            end
         end
         ST_MEASURE: begin
            if (rise) begin
               if (period_ok) begin
                  count_d = count_q + 8'd1;
                  if (count_d == MIN_COUNT) begin
                     detect_d = 1'b1;
                     state_d  = ST_QUALIFIED;
                  end
               end else begin
                  count_d = 8'd0;
               end
            end else if (over_limit) begin
               state_d = ST_IDLE;
            end
         end
         ST_QUALIFIED: begin
`ifdef BURST_QUALIFIER_STATS_EN
            if (rise && period_ok && (count_q != COUNT_MAX)) begin
               count_d = count_q + 8'd1;
            end
`endif
            if (!rise && timed_out) begin
               state_d = ST_IDLE;
`ifdef BURST_QUALIFIER_STATS_EN
               cycle_count_d = count_q;
               count_valid_d = 1'b1;
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      active_d = (state_d == ST_QUALIFIED);
   end

   // Register FSM state, counters and every output; reset aborts any burst silently.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         in_dly_q <= 1'b0;
         pcnt_q   <= '0;
         count_q  <= 8'd0;
         detect_q <= 1'b0;
         active_q <= 1'b0;
`ifdef BURST_QUALIFIER_STATS_EN
         cycle_count_q <= 8'd0;
         count_valid_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         in_dly_q <= in_dly_d;
         pcnt_q   <= pcnt_d;
         count_q  <= count_d;
         detect_q <= detect_d;
         active_q <= active_d;
`ifdef BURST_QUALIFIER_STATS_EN
         cycle_count_q <= cycle_count_d;
         count_valid_q <= count_valid_d;
`endif
      end
   end

   assign detect = detect_q;
   assign active = active_q;
`ifdef BURST_QUALIFIER_STATS_EN
   assign cycle_count = cycle_count_q;
   assign count_valid = count_valid_q;
`else
   assign cycle_count = 8'd0;
   assign count_valid = 1'b0;
`endif

endmodule

// File: tb/tb_burst_qualifier.sv
// tb_burst_qualifier: directed and randomized scenarios for burst_qualifier.
// Expectations come from an event-level model that works on the list of
// rising-edge times of the stimulus waveform, not on a cycle-level FSM.
module tb_burst_qualifier;
   import burst_qualifier_pkg::*;

   localparam int CPP     = DEF_CLKS_PER_PERIOD;
   localparam int TOL     = DEF_PERIOD_TOL;
   localparam int MIN_CYC = DEF_MIN_CYCLES;
   localparam int TMO     = DEF_TIMEOUT;
   localparam int MAXC    = 8192;
   localparam int START   = 4;
   localparam int TAIL    = 135;
`ifdef BURST_QUALIFIER_STATS_EN
   localparam bit STATS_EN = 1'b1;
`else
   localparam bit STATS_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       in_sig;
   logic       detect;
   logic       active;
   logic [7:0] cycle_count;
   logic       count_valid;

   int n_compared   = 0;
   int n_mismatched = 0;

   bit wave[MAXC];
   bit exp_det[MAXC];
   bit exp_act[MAXC];
   bit exp_cv[MAXC];
   int exp_cc[MAXC];
   int n_cycles;
   int reset_at;
   int period_q[$];

   int det_count, det_first, act_count, cv_count, cv_first, cv_val;

   burst_qualifier dut (
      .clk         (clk),
      .reset       (reset),
      .in          (in_sig),
      .detect      (detect),
      .active      (active),
      .cycle_count (cycle_count),
      .count_valid (count_valid)
   );

   // 10-unit clock period
   always #5 clk = ~clk;

   function automatic bit isValid(input int p);
      return (p >= CPP - TOL) && (p <= CPP + TOL);
   endfunction

   // One comparison: counts it, and on mismatch counts and reports it.
   task automatic check(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      assert (obs === exp) else begin
         n_mismatched++;
         $error("[TB] FAIL %s at cycle %0d: observed %0d, expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic addRun(input int p, input int n);
      for (int i = 0; i < n; i++) period_q.push_back(p);
   endtask

   // Turns the period list into a waveform: each rise held high for about half its period.
   task automatic buildWave();
      int t;
      int h;
      for (int i = 0; i < MAXC; i++) wave[i] = 1'b0;
      t = START;
      for (int i = 0; i <= period_q.size(); i++) begin
         h = ((i < period_q.size()) ? period_q[i] : 4) / 2;
         if (h < 1) h = 1;
         for (int j = 0; j < h; j++) wave[t + j] = 1'b1;
         if (i < period_q.size()) t = t + period_q[i];
      end
      n_cycles = t + TAIL;
   endtask

   // Edges at which in is first sampled high; a reset just before lo makes lo count as fresh.
   task automatic risesFrom(input int lo, input int hi, input bit fresh_start, output int rt[$]);
      bit prev;
      rt = {};
      for (int t = lo; t < hi; t++) begin
         prev = (t == 0) ? 1'b0 : wave[t - 1];
         if (t == lo && fresh_start) prev = 1'b0;
         if (wave[t] && !prev) rt.push_back(t);
      end
   endtask

   // Event-level model: a burst needs MIN_CYC valid periods in a row from its starting rise,
   // then lasts while gaps stay within TMO; paints expected outputs into cycles [lo,hi).
   task automatic paintModel(input int rt[$], input int lo, input int hi);
      int i, j, run, cnt, q_edge, last;
      i = 0;
      while (i < rt.size()) begin
         j = i;
         run = 0;
         while (run < MIN_CYC && j + 1 < rt.size() && isValid(rt[j + 1] - rt[j])) begin
            j++;
            run++;
         end
         if (run < MIN_CYC) begin
            i = j + 1;
         end else begin
            q_edge = rt[j];
            cnt = run;
            while (j + 1 < rt.size() && (rt[j + 1] - rt[j]) <= TMO) begin
               if (isValid(rt[j + 1] - rt[j]) && cnt < 255) cnt++;
               j++;
            end
            last = rt[j];
            if (q_edge + LATENCY - 1 >= lo && q_edge + LATENCY - 1 < hi) exp_det[q_edge + LATENCY - 1] = 1'b1;
            for (int c = q_edge + LATENCY - 1; c <= last + TMO + 1 && c < hi; c++)
               if (c >= lo) exp_act[c] = 1'b1;
            if (STATS_EN) begin
               if (last + TMO + 2 < hi) exp_cv[last + TMO + 2] = 1'b1;
               for (int c = last + TMO + 2; c < hi; c++) exp_cc[c] = cnt;
            end
            i = j + 1;
         end
      end
   endtask

   task automatic buildExpected();
      int ra[$];
      int rb[$];
      for (int c = 0; c < MAXC; c++) begin
         exp_det[c] = 1'b0;
         exp_act[c] = 1'b0;
         exp_cv[c]  = 1'b0;
         exp_cc[c]  = 0;
      end
      if (reset_at < 0) begin
         risesFrom(0, n_cycles, 1'b0, ra);
         paintModel(ra, 0, n_cycles);
      end else begin
         risesFrom(0, reset_at - 1, 1'b0, ra);
         paintModel(ra, 0, reset_at);
         risesFrom(reset_at + 1, n_cycles, 1'b1, rb);
         paintModel(rb, reset_at + 1, n_cycles);
      end
   endtask

   task automatic resetDut();
      reset  = 1'b1;
      in_sig = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_detect", -1, detect, 0);
      check("reset_active", -1, active, 0);
      check("reset_cycle_count", -1, cycle_count, 0);
      check("reset_count_valid", -1, count_valid, 0);
      reset = 1'b0;
   endtask

   task automatic checkOutput(input int k);
      check("detect", k, detect, exp_det[k]);
      check("active", k, active, exp_act[k]);
      check("count_valid", k, count_valid, exp_cv[k]);
      check("cycle_count", k, cycle_count, exp_cc[k]);
   endtask

   // Drives wave[k] so edge k samples it, then checks the outputs #1 after that edge.
   task automatic applyStimulus();
      det_count = 0; det_first = -1; act_count = 0;
      cv_count = 0; cv_first = -1; cv_val = -1;
      for (int k = 0; k < n_cycles; k++) begin
         in_sig = wave[k];
         reset  = (k == reset_at);
         @(posedge clk);
         #1;
         checkOutput(k);
         if (detect === 1'b1) begin
            det_count++;
            if (det_first < 0) det_first = k;
         end
         if (active === 1'b1) act_count++;
         if (count_valid === 1'b1) begin
            cv_count++;
            if (cv_first < 0) begin
               cv_first = k;
               cv_val = int'(cycle_count);
            end
         end
      end
      reset  = 1'b0;
      in_sig = 1'b0;
   endtask

   task automatic runScenario(input string name, input int rst_edge);
      reset_at = rst_edge;
      buildWave();
      buildExpected();
      resetDut();
      applyStimulus();
      $display("[TB] scenario %s: %0d cycles, %0d detect pulses", name, n_cycles, det_count);
      period_q = {};
   endtask

   // Linear sequence of directed scenarios followed by randomized rounds.
   initial begin
      int r;
      int p;
      int total;
      reset  = 1'b1;
      in_sig = 1'b0;

      // 12 rises at period 6: detect after the 5th rise, stats after 122 quiet cycles
      addRun(6, 11);
      runScenario("nominal_12", -1);
      check("nominal_detects", -1, det_count, 1);
      check("nominal_detect_cycle", -1, det_first, 30);
      check("nominal_cv_cycle", -1, cv_first, STATS_EN ? 193 : -1);
      check("nominal_cycle_count", -1, cv_val, STATS_EN ? 11 : -1);

      // period 9 never qualifies
      addRun(9, 20);
      runScenario("slow_9", -1);
      check("slow_detects", -1, det_count, 0);
      check("slow_active", -1, act_count, 0);
      check("slow_cv", -1, cv_count, 0);

      // tolerance edges 5 and 7 accepted
      addRun(5, 1); addRun(7, 1); addRun(6, 1); addRun(7, 1);
      runScenario("tol_5767", -1);
      check("tol_detect_cycle", -1, det_first, 31);

      // a 4-cycle period restarts the count
      addRun(6, 2); addRun(4, 1); addRun(6, 4);
      runScenario("short_4", -1);
      check("short_detects", -1, det_count, 1);
      check("short_detect_cycle", -1, det_first, 46);

      // an 8-cycle period restarts the count
      addRun(6, 1); addRun(8, 1); addRun(6, 4);
      runScenario("long_8", -1);
      check("long_detect_cycle", -1, det_first, 44);

      // 3 good, one gap of 10, 4 good: one detect after the second run
      addRun(6, 3); addRun(10, 1); addRun(6, 4);
      runScenario("gap_10", -1);
      check("gap_detects", -1, det_count, 1);
      check("gap_detect_cycle", -1, det_first, 58);

      // reset 20 cycles into a qualified burst, then a fresh 5-rise burst
      addRun(6, 7); addRun(34, 1); addRun(6, 4);
      runScenario("reset_mid", 50);
      check("reset_mid_detects", -1, det_count, 2);
      check("reset_mid_cv", -1, cv_count, STATS_EN ? 1 : 0);
      check("reset_mid_cycle_count", -1, cv_val, STATS_EN ? 4 : -1);

      // a 121-cycle gap keeps a qualified burst alive
      addRun(6, 4); addRun(121, 1); addRun(6, 2);
      runScenario("gap_121", -1);
      check("gap121_detects", -1, det_count, 1);
      check("gap121_cv_cycle", -1, cv_first, STATS_EN ? 284 : -1);
      check("gap121_cycle_count", -1, cv_val, STATS_EN ? 6 : -1);

      // a 122-cycle gap ends it; the next four periods qualify again
      addRun(6, 4); addRun(122, 1); addRun(6, 4);
      runScenario("gap_122", -1);
      check("gap122_detects", -1, det_count, 2);
      check("gap122_cv", -1, cv_count, STATS_EN ? 2 : 0);

      // long burst saturates the count at 255
      addRun(6, 260);
      runScenario("saturate", -1);
      check("saturate_cycle_count", -1, cv_val, STATS_EN ? 255 : -1);

      // randomized period mixes, mostly near nominal
      for (int round = 0; round < 3; round++) begin
         total = 0;
         for (int i = 0; i < 50; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      p = $urandom_range(4, 8);
            else if (r < 90) p = $urandom_range(2, 20);
            else             p = $urandom_range(115, 130);
            period_q.push_back(p);
            total += p;
         end
         runScenario("random", -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
